// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StWaitSync,
    StGetLen,
    StGetData,
    StGetChk,
    StDone
  } loader_state_e;

  localparam logic [7:0]  SyncByteDefault = 8'hA5;
  localparam int unsigned AddrWDefault    = 8;
  localparam int unsigned DataWDefault    = 8;

  // Number of bytes a LEN of zero stands for: a full memory image.
  function automatic int unsigned frame_len(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  localparam int unsigned FrameLenDefault = frame_len(AddrWDefault);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction memory write port of the loader.
interface imem_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Byte source and memory side.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  // Loader side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/imem_loader.sv
// Loads a checksummed byte-stream frame into instruction memory and holds the
// core in reset until a complete, verified image is in place.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = AddrWDefault,
  parameter int unsigned DATA_W    = DataWDefault,
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  input  logic         load_req,
  output logic         core_rst,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [ADDR_W:0] FullLen = (ADDR_W + 1)'(frame_len(ADDR_W));

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   remain_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        acc_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              core_rst_q, busy_q, done_q, err_q;

  logic            fire;
  logic [7:0]      acc_next;
  logic [ADDR_W:0] len_ext;

  assign fire     = bus.in_valid && in_ready_q;
  assign acc_next = acc_q + bus.in_data;
  assign len_ext  = (ADDR_W + 1)'(bus.in_data);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitSync: if (fire && bus.in_data == SYNC_BYTE) state_d = StGetLen;
      StGetLen:   if (fire) state_d = StGetData;
      StGetData:  if (fire && remain_q == (ADDR_W + 1)'(1)) state_d = StGetChk;
      StGetChk:   if (fire) state_d = (acc_next == 8'h00) ? StDone : StWaitSync;
      StDone:     if (load_req) state_d = StWaitSync;
      default:    state_d = StWaitSync;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StWaitSync;
      remain_q   <= '0;
      addr_q     <= '0;
      acc_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= 1'b0;
      // Status outputs track the next state so they line up with state_q.
      in_ready_q <= (state_d != StDone);
      core_rst_q <= (state_d != StDone);
      done_q     <= (state_d == StDone);
      busy_q     <= (state_d inside {StGetLen, StGetData, StGetChk});

      if (fire) begin
        unique case (state_q)
          StGetLen: begin
            remain_q <= (bus.in_data == 8'h00) ? FullLen : len_ext;
            addr_q   <= '0;
            acc_q    <= bus.in_data;
          end
          StGetData: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= DATA_W'(bus.in_data);
            addr_q    <= addr_q + ADDR_W'(1);
            remain_q  <= remain_q - (ADDR_W + 1)'(1);
            acc_q     <= acc_next;
          end
          StGetChk: err_q <= (acc_next != 8'h00);
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign core_rst     = core_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the processor's 256 x 8 instruction memory from a byte stream and holds the core in reset until a complete, checksum-verified image is in place. It is the writer side of the instruction memory the fetch stage reads through `PC`. It sits between an external byte source (UART receiver or testbench) and the instruction memory write port, and drives the processor's `rst`.

## Interface
- `ADDR_W`, default 8: instruction memory address width. The image holds at most 2^ADDR_W bytes.
- `DATA_W`, default 8: instruction width.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

- `clk`  in  1  single clock for the block.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  byte source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte. A transfer happens on any clock edge where `in_valid && in_ready`.
- `load_req`  in  1  request a reload. Honoured only in DONE.
- `wr_en`  out  1  instruction memory write strobe.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  DATA_W  write data.
- `core_rst`  out  1  reset for the processor (the core's `rst`).
- `busy`  out  1  a frame is in progress (GET_LEN, GET_DATA or GET_CHK).
- `done`  out  1  a valid image is loaded and the core is running.
- `err`  out  1  sticky flag: the last frame failed its checksum.

## Operation
- Frame format: SYNC_BYTE, LEN, LEN data bytes, CHK.
  - LEN = 0 means 2^ADDR_W bytes.
  - The frame is valid when (LEN + sum of data + CHK) mod 256 == 0.
- States:
  - WAIT_SYNC: bytes other than SYNC_BYTE are discarded. SYNC_BYTE moves to GET_LEN.
  - GET_LEN: latch LEN into the remaining-byte counter, clear the address counter, seed the checksum accumulator with LEN, then go to GET_DATA.
  - GET_DATA: each accepted byte is written to the current address. The address increments and wraps mod 2^ADDR_W, and the byte is added to the accumulator. After the LEN-th byte, go to GET_CHK.
  - GET_CHK: add CHK to the accumulator.
    - Sum == 0: go to DONE and clear `err`.
    - Sum != 0: set `err` and return to WAIT_SYNC.
  - DONE: `in_ready` = 0. `load_req` = 1 moves to WAIT_SYNC, clears `done` and re-asserts `core_rst`.
- `core_rst` = 1 in every state except DONE. A failed frame never releases the core. A partially written memory is harmless because the core stays in reset.
- `err` clears only on a successful frame or on `rst`. `load_req` does not clear it.
- SYNC_BYTE received inside GET_LEN, GET_DATA or GET_CHK is ordinary data. There is no resynchronisation mid-frame.
- Arithmetic:
  - The checksum accumulator is 8-bit and wraps.
  - The remaining-byte counter is ADDR_W+1 bits wide, so that LEN = 0 loads 2^ADDR_W.

## Timing
- Reset values: `in_ready` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `core_rst` 1, `busy` 0, `done` 0, `err` 0, state WAIT_SYNC.
- All outputs are registered. `in_ready` rises on the first clock edge after `rst` falls.
- Write latency: `wr_en`/`wr_addr`/`wr_data` are valid for exactly one cycle, the cycle after the data handshake. Exactly one write per accepted data byte.
- `in_ready` is computed from the next state. It is 0 from the cycle after CHK is accepted with a good sum. Throughput is one byte per cycle with no bubbles.
- `done` rises and `core_rst` falls on the same edge, the cycle after the CHK handshake. The last memory write completes on or before that edge.
- `load_req` to `core_rst` high: 1 cycle. `in_ready` goes high in that same cycle.
- Asserting `rst` mid-frame forces all reset values immediately. Any in-flight `wr_en` is dropped. The next frame starts at address 0.

## Structure
- Shared package `loader_pkg`:
  - state enum (WAIT_SYNC, GET_LEN, GET_DATA, GET_CHK, DONE)
  - `SYNC_BYTE` default
  - frame-length constant 2^ADDR_W
- Single module with no sub-module. The FSM, counters and accumulator are small enough to keep together.

## Test plan
- Good frame, back-to-back bytes: after `rst`, send A5 03 11 22 33 97.
  - Required: writes [0]=11, [1]=22, [2]=33, one cycle each.
  - Required: `done` = 1 and `core_rst` = 0 one cycle after 97 is accepted; `err` = 0.
- Junk before sync: send 00 FF 3C, then the frame above. Required: no `wr_en` before A5; result identical to the good-frame case.
- Bad checksum: send A5 03 11 22 33 98.
  - Required: `err` = 1, `core_rst` stays 1, `in_ready` stays 1, state WAIT_SYNC.
  - Then send the good frame. Required: `err` = 0, `done` = 1.
- Full image: send A5 00, bytes i = 0..255 (value i), then CHK = 0x80.
  - Required: 256 writes, addresses 0..255; `done` = 1.
- Backpressure, reload and reset:
  - Toggle `in_valid` randomly during the frame. Required: one write per handshake and correct addresses.
  - In DONE, pulse `load_req`. Required: `core_rst` = 1 and `done` = 0 next cycle.
  - Assert `rst` after 2 data bytes. Required: all outputs at reset values immediately; a subsequent frame writes from address 0.
